rn_release_sequencer: RTL

- Controller for banks of async-reset (active-low RN) flip-flops grouped into NDOM reset domains.
- Owns every domain's RN line. Guarantees a minimum RN low pulse width, releases RN synchronously to CLK with a recovery/removal guard, and staggers releases at power-on.
- Arbitrates per-domain soft-reset requests round-robin, serving one domain at a time.

---
 rtl/rn_seq_pkg.sv | 28 ++
 rtl/rn_seq_rr_arb.sv | 55 +++++
 rtl/rn_release_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rn_seq_pkg.sv
// Shared types and elaboration helpers for the RN release sequencer.
package rn_seq_pkg;

  typedef enum logic [2:0] {
    S_PON_HOLD,
    S_PON_REL,
    S_IDLE,
    S_ASSERT,
    S_GAP,
    S_ACK
  } state_t;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int assert_cyc, input int gap_cyc);
    return clog2w((assert_cyc > gap_cyc) ? assert_cyc : gap_cyc);
  endfunction

  function automatic bit params_ok(input int ndom, input int assert_cyc,
                                   input int gap_cyc, input int sync_stages);
    return (ndom >= 1) && (ndom <= 32) && (assert_cyc >= 1) &&
           (gap_cyc >= 1) && (sync_stages >= 2);
  endfunction

endpackage

// File: rtl/rn_seq_rr_arb.sv
// Round-robin arbiter: lowest eligible index at or after the pointer wins.
module rn_seq_rr_arb
  import rn_seq_pkg::*;
#(
  parameter int NDOM = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NDOM-1:0]          req,
  input  logic [NDOM-1:0]          mask,
  input  logic                     advance,
  output logic [clog2w(NDOM)-1:0]  grant,
  output logic                     valid
);

  localparam int IW = clog2w(NDOM);

  logic [IW-1:0]   ptr_reg;
  logic [IW-1:0]   ptr_next;
  logic [NDOM-1:0] elig;
  logic [NDOM-1:0] rot;

  assign elig = req & ~mask;
  // Rotate so that bit 0 of rot is the domain the pointer names.
  assign rot  = NDOM'({elig, elig} >> ptr_reg);

  always_comb begin
    int s;
    s     = 0;
    valid = 1'b0;
    grant = '0;
    // Downward scan so the smallest offset from the pointer is kept last.
    for (int k = NDOM - 1; k >= 0; k--) begin
      if (rot[k]) begin
        s = int'(ptr_reg) + k;
        if (s >= NDOM) s = s - NDOM;
        valid = 1'b1;
        grant = IW'(s);
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (advance && valid) begin
      ptr_next = (grant == IW'(NDOM - 1)) ? '0 : grant + IW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/rn_release_sequencer.sv
// Drives per-domain active-low RN lines: staggered power-on release, then
// round-robin soft resets with a minimum low width and a post-release guard.
module rn_release_sequencer
  import rn_seq_pkg::*;
#(
  parameter int NDOM        = 4,
  parameter int ASSERT_CYC  = 4,
  parameter int GAP_CYC     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NDOM-1:0]          REQ,
  output logic [NDOM-1:0]          ACK,
  output logic [NDOM-1:0]          RN,
  output logic                     BUSY,
  output logic [clog2w(NDOM)-1:0]  CUR
);

  localparam int IW = clog2w(NDOM);
  localparam int XW = clog2w(NDOM + 1);
  localparam int CW = cnt_width(ASSERT_CYC, GAP_CYC);
  localparam logic [CW-1:0] A_LOAD = CW'(ASSERT_CYC - 1);
  localparam logic [CW-1:0] G_LOAD = CW'(GAP_CYC - 1);

  if (!params_ok(NDOM, ASSERT_CYC, GAP_CYC, SYNC_STAGES)) begin : g_param_check
    $error("rn_release_sequencer: illegal NDOM/ASSERT_CYC/GAP_CYC/SYNC_STAGES");
  end

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   srst_sync;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [XW-1:0]   idx_reg, idx_next;
  logic [NDOM-1:0] rn_reg, rn_next;
  logic [NDOM-1:0] ack_reg, ack_next;
  logic [IW-1:0]   cur_reg, cur_next;

  logic [IW-1:0]   gnt;
  logic            gnt_valid;
  logic            advance;
  logic [NDOM-1:0] arb_mask;
  logic [NDOM-1:0] gnt_oh;
  logic [NDOM-1:0] cur_oh;
  logic [NDOM-1:0] pon_oh;

  // Asserts with RST, releases only after SYNC_STAGES clean edges.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_reg <= '1;
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b0};
  end
  assign srst_sync = sync_reg[SYNC_STAGES-1];

  for (genvar gi = 0; gi < NDOM; gi++) begin : g_dec
    assign gnt_oh[gi] = (gnt == IW'(gi));
    assign cur_oh[gi] = (cur_reg == IW'(gi));
    assign pon_oh[gi] = (idx_reg == XW'(gi));
  end

  // The domain just acknowledged may not win the edge its ACK clears on.
  assign arb_mask = (state_reg == S_ACK) ? cur_oh : '0;

  rn_seq_rr_arb #(
    .NDOM (NDOM)
  ) u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (REQ),
    .mask    (arb_mask),
    .advance (advance),
    .grant   (gnt),
    .valid   (gnt_valid)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    rn_next    = rn_reg;
    ack_next   = '0;
    cur_next   = cur_reg;
    advance    = 1'b0;
    case (state_reg)
      S_PON_HOLD: begin
        if (cnt_reg == '0) begin
          rn_next[0] = 1'b1;
          idx_next   = XW'(1);
          cnt_next   = G_LOAD;
          state_next = S_PON_REL;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_PON_REL: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end else if (idx_reg == XW'(NDOM)) begin
          state_next = S_IDLE;
        end else begin
          rn_next  = rn_reg | pon_oh;
          idx_next = idx_reg + XW'(1);
          cnt_next = G_LOAD;
        end
      end
      S_IDLE, S_ACK: begin
        if (gnt_valid) begin
          cur_next   = gnt;
          rn_next    = ~gnt_oh;
          advance    = 1'b1;
          cnt_next   = A_LOAD;
          state_next = S_ASSERT;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ASSERT: begin
        if (cnt_reg == '0) begin
          rn_next    = '1;
          cnt_next   = G_LOAD;
          state_next = S_GAP;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_reg == '0) begin
          ack_next   = cur_oh;
          state_next = S_ACK;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = S_PON_HOLD;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= S_PON_HOLD;
      cnt_reg   <= A_LOAD;
      idx_reg   <= '0;
      rn_reg    <= '0;
      ack_reg   <= '0;
      cur_reg   <= '0;
    end else if (srst_sync) begin
      state_reg <= S_PON_HOLD;
      cnt_reg   <= A_LOAD;
      idx_reg   <= '0;
      rn_reg    <= '0;
      ack_reg   <= '0;
      cur_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      rn_reg    <= rn_next;
      ack_reg   <= ack_next;
      cur_reg   <= cur_next;
    end
  end

  assign RN   = rn_reg;
  assign ACK  = ack_reg;
  assign CUR  = cur_reg;
  assign BUSY = (state_reg != S_IDLE);

endmodule
